// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - select encodings and FSM states for the stereo frame serializer
// STEREO_PARITY_EN adds the PARITY state.
package stereo_pkg;

   localparam logic [1:0] SEL_LEFT  = 2'd0;
   localparam logic [1:0] SEL_RIGHT = 2'd1;
   localparam logic [1:0] SEL_AUX   = 2'd2;
   localparam logic [1:0] SEL_IDLE  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_LEFT   = 3'd2,
`ifdef STEREO_PARITY_EN
      ST_RIGHT  = 3'd3,
      ST_PARITY = 3'd4
`else
      ST_RIGHT  = 3'd3
`endif
   } state_t;

endpackage

// File: rtl/stereo_bit_tick.sv
// rtl/stereo_bit_tick.sv - CLK_DIV prescaler producing one slot_end per bit slot
// Cleared on sample acceptance so every frame starts slot-aligned.
module stereo_bit_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic slot_end
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign slot_end = enable & (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || slot_end) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/stereo_frame_serializer.sv
// rtl/stereo_frame_serializer.sv - serialises a left/right sample pair as sync, left, right slots
// Optional STEREO_PARITY_EN appends an even-parity slot after RIGHT.
module stereo_frame_serializer
   import stereo_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int CLK_DIV  = 4,
   parameter int SYNC_LEN = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic [1:0]          mux_sel,
   output logic                bit_a,
   output logic                bit_b,
   output logic                bit_c,
   output logic                frame_start,
   output logic                busy
);

   localparam int BIT_MAX = (SYNC_LEN > SAMPLE_W) ? SYNC_LEN : SAMPLE_W;
   localparam int BCW     = $clog2(BIT_MAX);

   state_t              state;
   state_t              state_next;
   logic                slot_end;
   logic                bit_last;
   logic                accept;
   logic                ready_raw;
   logic [BCW-1:0]      bit_cnt;
   logic [SAMPLE_W-1:0] sh_left;
   logic [SAMPLE_W-1:0] sh_right;
`ifdef STEREO_PARITY_EN
   logic                parity;
`endif

   stereo_bit_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept),
      .enable   (state != ST_IDLE),
      .slot_end (slot_end)
   );

   always_comb begin
      bit_last = 1'b0;
      case (state)
         ST_SYNC: bit_last = (bit_cnt == BCW'(SYNC_LEN - 1));
         default: bit_last = (bit_cnt == BCW'(SAMPLE_W - 1));
      endcase
   end

   always_comb begin
      ready_raw  = 1'b0;
      state_next = state;
      case (state)
         ST_IDLE: ready_raw = 1'b1;
`ifdef STEREO_PARITY_EN
         ST_PARITY: ready_raw = slot_end;
`else
         ST_RIGHT: ready_raw = slot_end & bit_last;
`endif
         default: ready_raw = 1'b0;
      endcase
      s_ready = ready_raw & rst_n;
      accept  = s_valid & s_ready;

      case (state)
         ST_IDLE: if (accept) state_next = ST_SYNC;
         ST_SYNC: if (slot_end && bit_last) state_next = ST_LEFT;
         ST_LEFT: if (slot_end && bit_last) state_next = ST_RIGHT;
`ifdef STEREO_PARITY_EN
         ST_RIGHT:  if (slot_end && bit_last) state_next = ST_PARITY;
         ST_PARITY: if (slot_end) state_next = accept ? ST_SYNC : ST_IDLE;
`else
         ST_RIGHT: if (slot_end && bit_last) state_next = accept ? ST_SYNC : ST_IDLE;
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs are registered alongside the state, so each branch loads what the next clock shows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= '0;
         sh_left     <= '0;
         sh_right    <= '0;
         mux_sel     <= SEL_IDLE;
         bit_a       <= 1'b0;
         bit_b       <= 1'b0;
         bit_c       <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
`ifdef STEREO_PARITY_EN
         parity      <= 1'b0;
`endif
      end else begin
         frame_start <= 1'b0;
         if (accept) begin
            sh_left     <= s_left;
            sh_right    <= s_right;
            bit_cnt     <= '0;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            mux_sel     <= SEL_AUX;
            bit_a       <= 1'b0;
            bit_b       <= 1'b0;
            bit_c       <= 1'b1;
`ifdef STEREO_PARITY_EN
            parity      <= (^s_left) ^ (^s_right);
`endif
         end else if (slot_end) begin
            case (state)
               ST_SYNC: begin
                  if (bit_last) begin
                     bit_cnt <= '0;
                     mux_sel <= SEL_LEFT;
                     bit_c   <= 1'b0;
                     bit_a   <= sh_left[SAMPLE_W-1];
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                     bit_c   <= ~bit_c;
                  end
               end
               ST_LEFT: begin
                  if (bit_last) begin
                     bit_cnt <= '0;
                     mux_sel <= SEL_RIGHT;
                     bit_a   <= 1'b0;
                     bit_b   <= sh_right[SAMPLE_W-1];
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                     sh_left <= {sh_left[SAMPLE_W-2:0], 1'b0};
                     bit_a   <= sh_left[SAMPLE_W-2];
                  end
               end
               ST_RIGHT: begin
                  if (bit_last) begin
                     bit_cnt <= '0;
                     bit_b   <= 1'b0;
`ifdef STEREO_PARITY_EN
                     mux_sel <= SEL_AUX;
                     bit_c   <= parity;
`else
                     mux_sel <= SEL_IDLE;
                     busy    <= 1'b0;
`endif
                  end else begin
                     bit_cnt  <= bit_cnt + BCW'(1);
                     sh_right <= {sh_right[SAMPLE_W-2:0], 1'b0};
                     bit_b    <= sh_right[SAMPLE_W-2];
                  end
               end
`ifdef STEREO_PARITY_EN
               ST_PARITY: begin
                  mux_sel <= SEL_IDLE;
                  bit_c   <= 1'b0;
                  busy    <= 1'b0;
               end
`endif
               default: begin
                  mux_sel <= SEL_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stereo_frame_serializer.sv
// tb/tb_stereo_frame_serializer.sv - directed self-checking bench for stereo_frame_serializer
// Honours STEREO_PARITY_EN when defined.
module tb_stereo_frame_serializer;

`ifdef STEREO_PARITY_EN
   localparam int FRAME   = (4 + 32) * 4 + 4;
   localparam int MIN_LEN = 6;
`else
   localparam int FRAME   = (4 + 32) * 4;
   localparam int MIN_LEN = 5;
`endif

   logic        clk;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_left;
   logic [15:0] s_right;
   logic [1:0]  mux_sel;
   logic        bit_a, bit_b, bit_c, frame_start, busy;

   logic        m_valid;
   logic        m_ready;
   logic [1:0]  m_left;
   logic [1:0]  m_right;
   logic [1:0]  m_mux;
   logic        m_a, m_b, m_c, m_fs, m_busy;

   int checks;
   int passed;

   stereo_frame_serializer u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_left      (s_left),
      .s_right     (s_right),
      .mux_sel     (mux_sel),
      .bit_a       (bit_a),
      .bit_b       (bit_b),
      .bit_c       (bit_c),
      .frame_start (frame_start),
      .busy        (busy)
   );

   stereo_frame_serializer #(
      .SAMPLE_W (2),
      .CLK_DIV  (1),
      .SYNC_LEN (1)
   ) u_min (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (m_valid),
      .s_ready     (m_ready),
      .s_left      (m_left),
      .s_right     (m_right),
      .mux_sel     (m_mux),
      .bit_a       (m_a),
      .bit_b       (m_b),
      .bit_c       (m_c),
      .frame_start (m_fs),
      .busy        (m_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected {mux_sel, bit_a, bit_b, bit_c} in clock k (1-based) of a default-parameter frame.
   function automatic logic [4:0] exp_out(input int k, input logic [15:0] l, input logic [15:0] r);
      int slot;
      slot = (k - 1) / 4;
      if (slot < 4)       return {2'd2, 1'b0, 1'b0, (slot % 2) == 0};
      else if (slot < 20) return {2'd0, l[19 - slot], 1'b0, 1'b0};
      else if (slot < 36) return {2'd1, 1'b0, r[35 - slot], 1'b0};
      else                return {2'd2, 1'b0, 1'b0, ^{l, r}};
   endfunction

   task automatic test_reset;
      checks++;
      if (s_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", s_ready); else passed++;
      checks++;
      if (mux_sel !== 2'd3) $display("FAIL reset_mux got %0d want 3", mux_sel); else passed++;
      checks++;
      if ({bit_a, bit_b, bit_c, frame_start, busy} !== 5'b0)
         $display("FAIL reset_bits got %b want 00000", {bit_a, bit_b, bit_c, frame_start, busy});
      else passed++;
      checks++;
      if ({m_ready, m_mux, m_busy} !== 4'b1110)
         $display("FAIL reset_min got %b want 1110", {m_ready, m_mux, m_busy});
      else passed++;
   endtask

   task automatic test_single_frame(input logic [15:0] l, input logic [15:0] r);
      logic [7:0] obs, expv;
      s_left = l; s_right = r; s_valid = 1'b1;
      checks++;
      if (s_ready !== 1'b1) $display("FAIL single_idle_ready got %b want 1", s_ready); else passed++;
      tick;
      s_valid = 1'b0;
      for (int k = 1; k <= FRAME; k++) begin
         obs  = {mux_sel, bit_a, bit_b, bit_c, frame_start, busy, s_ready};
         expv = {exp_out(k, l, r), k == 1, 1'b1, k == FRAME};
         checks++;
         if (obs !== expv) $display("FAIL single_%h_%h k=%0d got %b want %b", l, r, k, obs, expv);
         else passed++;
         tick;
      end
      obs = {mux_sel, bit_a, bit_b, bit_c, frame_start, busy, s_ready};
      checks++;
      if (obs !== 8'b11000001) $display("FAIL single_end_idle got %b want 11000001", obs); else passed++;
   endtask

   task automatic test_back_to_back;
      logic [7:0] obs, expv;
      s_left = 16'h1234; s_right = 16'h8001; s_valid = 1'b1;
      tick;
      s_left = 16'hC001; s_right = 16'h7FFE;
      for (int k = 1; k <= FRAME; k++) begin
         obs  = {mux_sel, bit_a, bit_b, bit_c, frame_start, busy, s_ready};
         expv = {exp_out(k, 16'h1234, 16'h8001), k == 1, 1'b1, k == FRAME};
         checks++;
         if (obs !== expv) $display("FAIL b2b_first k=%0d got %b want %b", k, obs, expv); else passed++;
         tick;
      end
      s_valid = 1'b0;
      for (int k = 1; k <= FRAME; k++) begin
         obs  = {mux_sel, bit_a, bit_b, bit_c, frame_start, busy, s_ready};
         expv = {exp_out(k, 16'hC001, 16'h7FFE), k == 1, 1'b1, k == FRAME};
         checks++;
         if (obs !== expv) $display("FAIL b2b_second k=%0d got %b want %b", k, obs, expv); else passed++;
         tick;
      end
      obs = {mux_sel, bit_a, bit_b, bit_c, frame_start, busy, s_ready};
      checks++;
      if (obs !== 8'b11000001) $display("FAIL b2b_end_idle got %b want 11000001", obs); else passed++;
   endtask

   task automatic test_input_isolation;
      logic [4:0] obs;
      s_left = 16'hA5C3; s_right = 16'h0F0F; s_valid = 1'b1;
      tick;
      s_valid = 1'b0;
      for (int k = 1; k <= FRAME; k++) begin
         if (k == 2) begin
            s_left = 16'hFFFF; s_right = 16'h0000;
         end
         obs = {mux_sel, bit_a, bit_b, bit_c};
         checks++;
         if (obs !== exp_out(k, 16'hA5C3, 16'h0F0F))
            $display("FAIL isolation k=%0d got %b want %b", k, obs, exp_out(k, 16'hA5C3, 16'h0F0F));
         else passed++;
         tick;
      end
      checks++;
      if (busy !== 1'b0) $display("FAIL isolation_end_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_reset_mid_frame;
      logic [6:0] obs;
      s_left = 16'hA5C3; s_right = 16'h0F0F; s_valid = 1'b1;
      tick;
      s_valid = 1'b0;
      for (int k = 1; k < 30; k++) tick;
      checks++;
      if ({mux_sel, busy} !== 3'b001) $display("FAIL midleft_state got %b want 001", {mux_sel, busy}); else passed++;
      rst_n = 1'b0;
      #1;
      obs = {mux_sel, bit_a, bit_b, bit_c, frame_start, s_ready};
      checks++;
      if (obs !== 7'b1100000) $display("FAIL async_reset got %b want 1100000", obs); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL async_reset_busy got %b want 0", busy); else passed++;
      tick;
      tick;
      rst_n = 1'b1;
      #1;
      checks++;
      if ({s_ready, mux_sel} !== 3'b111) $display("FAIL reset_release got %b want 111", {s_ready, mux_sel}); else passed++;
      tick;
      obs = {mux_sel, bit_a, bit_b, bit_c, frame_start, s_ready};
      checks++;
      if (obs !== 7'b1100001) $display("FAIL reset_stays_idle got %b want 1100001", obs); else passed++;
   endtask

   task automatic test_min_divider;
      logic [1:0] em [0:5];
      logic       eb [0:5];
      logic [7:0] obs, expv;
      em = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
      eb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      m_left = 2'b10; m_right = 2'b01; m_valid = 1'b1;
      tick;
      m_valid = 1'b0;
      for (int k = 1; k <= MIN_LEN; k++) begin
         obs  = {m_mux, m_a, m_b, m_c, m_fs, m_busy, m_ready};
         expv = {em[k-1], (em[k-1] == 2'd0) & eb[k-1], (em[k-1] == 2'd1) & eb[k-1],
                 (em[k-1] == 2'd2) & eb[k-1], k == 1, 1'b1, k == MIN_LEN};
         checks++;
         if (obs !== expv) $display("FAIL min_div k=%0d got %b want %b", k, obs, expv); else passed++;
         tick;
      end
      obs = {m_mux, m_a, m_b, m_c, m_fs, m_busy, m_ready};
      checks++;
      if (obs !== 8'b11000001) $display("FAIL min_div_idle got %b want 11000001", obs); else passed++;
   endtask

`ifdef STEREO_PARITY_EN
   task automatic test_parity;
      s_left = 16'h0001; s_right = 16'h0000; s_valid = 1'b1;
      tick;
      s_valid = 1'b0;
      for (int k = 1; k <= FRAME; k++) begin
         if (k > FRAME - 4) begin
            checks++;
            if ({mux_sel, bit_c, busy} !== 4'b1011)
               $display("FAIL parity_slot k=%0d got %b want 1011", k, {mux_sel, bit_c, busy});
            else passed++;
         end
         tick;
      end
      checks++;
      if ({mux_sel, busy} !== 3'b110) $display("FAIL parity_end got %b want 110", {mux_sel, busy}); else passed++;
   endtask
`endif

   initial begin
      checks  = 0;
      passed  = 0;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_left  = '0;
      s_right = '0;
      m_valid = 1'b0;
      m_left  = '0;
      m_right = '0;
      #2;
      checks++;
      if (s_ready !== 1'b0) $display("FAIL ready_in_reset got %b want 0", s_ready); else passed++;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      test_reset;
      test_single_frame(16'hA5C3, 16'h0F0F);
      test_back_to_back;
      test_input_isolation;
      test_reset_mid_frame;
      test_min_divider;
`ifdef STEREO_PARITY_EN
      test_parity;
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
